// File: rtl/c432_response_monitor_pkg.sv
// Shared definitions for the Circuit432 response monitor and its upstream pattern generator.
package c432_mon_pkg;
   localparam int          OUT_W     = 7;
   localparam int          SIG_W     = 16;
   localparam int          CNT_W     = 16;
   localparam logic [15:0] MISR_POLY = 16'h1021;
   localparam logic [15:0] MISR_SEED = 16'hFFFF;

   typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;
endpackage

// File: rtl/c432_response_monitor_if.sv
// Control/response bundle between the test controller, the wrapper output and the monitor.
interface c432_response_monitor_if #(
   parameter int OUT_W = c432_mon_pkg::OUT_W,
   parameter int SIG_W = c432_mon_pkg::SIG_W,
   parameter int CNT_W = c432_mon_pkg::CNT_W
);
   import c432_mon_pkg::*;

   logic             start;
   logic [CNT_W-1:0] num_patterns;
   logic [SIG_W-1:0] golden_sig;
   logic             resp_valid;
   logic [OUT_W-1:0] resp_val;
   logic             busy;
   logic             done;
   logic             pass;
   logic [SIG_W-1:0] signature;
   logic [CNT_W-1:0] pat_count;

   modport master (
      output start, num_patterns, golden_sig, resp_valid, resp_val,
      input  busy, done, pass, signature, pat_count
   );

   modport slave (
      input  start, num_patterns, golden_sig, resp_valid, resp_val,
      output busy, done, pass, signature, pat_count
   );
endinterface

// File: rtl/c432_response_monitor_misr.sv
// Multiple-input signature register: seed load takes priority over compaction.
module c432_misr #(
   parameter int               OUT_W     = c432_mon_pkg::OUT_W,
   parameter int               SIG_W     = c432_mon_pkg::SIG_W,
   parameter logic [SIG_W-1:0] MISR_POLY = c432_mon_pkg::MISR_POLY,
   parameter logic [SIG_W-1:0] MISR_SEED = c432_mon_pkg::MISR_SEED
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic             i_en,
   input  logic [OUT_W-1:0] i_data,
   output logic [SIG_W-1:0] o_sig
);
   logic [SIG_W-1:0] r_sig;
   logic [SIG_W-1:0] w_fb;
   logic [SIG_W-1:0] w_next;

   assign w_fb   = r_sig[SIG_W-1] ? MISR_POLY : '0;
   assign w_next = {r_sig[SIG_W-2:0], 1'b0} ^ w_fb ^ {{(SIG_W-OUT_W){1'b0}}, i_data};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sig <= '0;
      end else if (i_load) begin
         r_sig <= MISR_SEED;
      end else if (i_en) begin
         r_sig <= w_next;
      end
   end

   assign o_sig = r_sig;
endmodule

// File: rtl/c432_response_monitor.sv
// Go/no-go capture stage: compacts a programmed number of wrapper responses and
// compares the final MISR signature against a golden value.
module c432_response_monitor #(
   parameter int               OUT_W     = c432_mon_pkg::OUT_W,
   parameter int               SIG_W     = c432_mon_pkg::SIG_W,
   parameter int               CNT_W     = c432_mon_pkg::CNT_W,
   parameter logic [SIG_W-1:0] MISR_POLY = c432_mon_pkg::MISR_POLY,
   parameter logic [SIG_W-1:0] MISR_SEED = c432_mon_pkg::MISR_SEED
) (
   input logic                     clk,
   input logic                     rst_n,
   c432_response_monitor_if.slave  bus
);
   import c432_mon_pkg::*;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_target;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic             w_load;
   logic             w_en;
   logic [SIG_W-1:0] w_sig;

   assign w_cnt_inc = r_cnt + 1'b1;

   // Start is only honoured when idle or finished, and it pre-empts a coincident response.
   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      w_en   = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (bus.start) begin
               w_load = 1'b1;
               w_next = (bus.num_patterns == '0) ? CHECK : RUN;
            end
         end
         RUN: begin
            if (bus.resp_valid) begin
               w_en = 1'b1;
               if (w_cnt_inc == r_target) w_next = CHECK;
            end
         end
         CHECK:   w_next = DONE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_pass   <= 1'b0;
         r_cnt    <= '0;
         r_target <= '0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next == RUN) || (w_next == CHECK);
         r_done  <= (w_next == DONE);
         if (w_load) begin
            r_cnt    <= '0;
            r_target <= bus.num_patterns;
            r_pass   <= 1'b0;
         end else if (w_en) begin
            r_cnt <= w_cnt_inc;
         end
         if (r_state == CHECK) r_pass <= (w_sig == bus.golden_sig);
      end
   end

   c432_misr #(
      .OUT_W     (OUT_W),
      .SIG_W     (SIG_W),
      .MISR_POLY (MISR_POLY),
      .MISR_SEED (MISR_SEED)
   ) u_misr (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load),
      .i_en   (w_en),
      .i_data (bus.resp_val),
      .o_sig  (w_sig)
   );

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.pass      = r_pass;
   assign bus.signature = w_sig;
   assign bus.pat_count = r_cnt;
endmodule

// File: tb/tb_c432_response_monitor.sv
// Scoreboard bench for the Circuit432 response monitor with an arithmetic signature model.
module tb_c432_response_monitor;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   typedef struct {
      logic [15:0] sig;
      logic        pass;
      logic [15:0] cnt;
      int          due;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   logic prev_done = 1'b0;

   c432_response_monitor_if bus ();

   c432_response_monitor dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Signature as polynomial arithmetic: double, reduce modulo the generator, add the response.
   function automatic logic [15:0] model(input logic [6:0] q[$]);
      int s;
      s = 'hFFFF;
      foreach (q[k]) begin
         s = s * 2;
         if (s >= 65536) s = (s - 65536) ^ 'h1021;
         s = s ^ int'(q[k]);
      end
      return 16'(s);
   endfunction

   always @(negedge clk) begin
      if (bus.done && !prev_done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("sig", {16'h0, bus.signature}, {16'h0, mon_e.sig});
            check("pass", {31'h0, bus.pass}, {31'h0, mon_e.pass});
            check("pat_count", {16'h0, bus.pat_count}, {16'h0, mon_e.cnt});
            check("latency", cyc, mon_e.due);
         end
      end
      prev_done = bus.done;
   end

   task automatic run(input int n, input int fixed, input bit gapped, input bit start_mid,
                      input logic [15:0] gxor, input bit use_lit, input logic [15:0] lit);
      logic [6:0]  q[$];
      logic [15:0] es;
      int          due;
      bit          got;
      exp_t        e;
      for (int k = 0; k < n; k++) q.push_back(fixed < 0 ? 7'($urandom) : 7'(fixed));
      es = model(q);
      bus.golden_sig   = es ^ gxor;
      bus.num_patterns = 16'(n);
      bus.start        = 1'b1;
      bus.resp_valid   = 1'b1;
      bus.resp_val     = 7'($urandom);
      due = cyc + 2;
      tick();
      bus.start      = 1'b0;
      bus.resp_valid = 1'b0;
      check("start_done_clr", {31'h0, bus.done}, 32'd0);
      check("start_seed", {16'h0, bus.signature}, 32'h0000FFFF);
      check("start_cnt", {16'h0, bus.pat_count}, 32'd0);
      check("start_busy", {31'h0, bus.busy}, 32'd1);
      for (int k = 0; k < n; k++) begin
         if (gapped) begin
            repeat ($urandom_range(0, 2)) begin
               bus.resp_valid = 1'b0;
               bus.resp_val   = 7'($urandom);
               tick();
            end
         end
         if (start_mid && k == n / 2) begin
            bus.start        = 1'b1;
            bus.resp_valid   = 1'b0;
            bus.num_patterns = 16'd1;
            tick();
            bus.start        = 1'b0;
            bus.num_patterns = 16'(n);
            check("mid_start_cnt", {16'h0, bus.pat_count}, k);
            check("mid_start_busy", {31'h0, bus.busy}, 32'd1);
         end
         bus.resp_valid = 1'b1;
         bus.resp_val   = q[k];
         due = cyc + 2;
         tick();
      end
      e.sig  = es;
      e.pass = (gxor == 16'h0);
      e.cnt  = 16'(n);
      e.due  = due;
      sb.push_back(e);
      // The CHECK cycle sees a valid response that must not be compacted.
      bus.resp_valid = 1'b1;
      bus.resp_val   = 7'($urandom);
      got = 1'b0;
      for (int w = 0; w < 10 && !got; w++) begin
         tick();
         if (bus.done) got = 1'b1;
      end
      check("done_timeout", {31'h0, got}, 32'd1);
      repeat (2) begin
         bus.resp_val = 7'($urandom);
         tick();
      end
      bus.resp_valid = 1'b0;
      check("hold_sig", {16'h0, bus.signature}, {16'h0, es});
      check("hold_cnt", {16'h0, bus.pat_count}, n);
      check("hold_done", {31'h0, bus.done}, 32'd1);
      check("hold_busy", {31'h0, bus.busy}, 32'd0);
      if (use_lit) check("golden_vector", {16'h0, bus.signature}, {16'h0, lit});
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, {31'h0, bus.busy}, 32'd0);
      check({tag, "_done"}, {31'h0, bus.done}, 32'd0);
      check({tag, "_pass"}, {31'h0, bus.pass}, 32'd0);
      check({tag, "_sig"}, {16'h0, bus.signature}, 32'd0);
      check({tag, "_cnt"}, {16'h0, bus.pat_count}, 32'd0);
   endtask

   initial begin
      bus.start        = 1'b0;
      bus.num_patterns = '0;
      bus.golden_sig   = '0;
      bus.resp_valid   = 1'b0;
      bus.resp_val     = '0;
      repeat (3) tick();
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();

      run(1, 0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hEFDF);
      run(1, 0, 1'b0, 1'b0, 16'h0001, 1'b1, 16'hEFDF);
      run(1, 127, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hEFA0);
      run(0, 0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFF);
      run(4, -1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
      run(6, -1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000);

      // Abort a run with an asynchronous reset pulse placed between clock edges.
      bus.num_patterns = 16'd10;
      bus.start        = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bus.resp_valid = 1'b1;
         bus.resp_val   = 7'($urandom);
         tick();
      end
      bus.resp_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_rst");
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      check_all_zero("post_rst");
      run(1, 0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hEFDF);

      for (int r = 0; r < 25; r++) begin
         run($urandom_range(0, 12), -1, 1'($urandom), 1'($urandom_range(0, 3) == 0),
             ($urandom_range(0, 1) == 0) ? 16'h0000 : (16'h0001 << $urandom_range(0, 15)),
             1'b0, 16'h0000);
      end

      for (int w = 0; w < 20 && sb.size() != 0; w++) tick();
      check("scoreboard_drain", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
